// File: rtl/three_phase_lut_scheduler_if.sv
// Bus between the three-phase LUT scheduler, the shared sine ROM and the modulator stage.
interface three_phase_lut_scheduler_if #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned ADDR_W = 14
);
    logic              en;
    logic              rom_rd;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [DATA_W-1:0] out_c;
    logic              out_valid;
    logic              busy;

    // Scheduler side.
    modport master (
        input  en,
        input  rom_data,
        output rom_rd,
        output rom_addr,
        output out_a,
        output out_b,
        output out_c,
        output out_valid,
        output busy
    );

    // Environment side: ROM, enable source and sample consumer.
    modport slave (
        output en,
        output rom_data,
        input  rom_rd,
        input  rom_addr,
        input  out_a,
        input  out_b,
        input  out_c,
        input  out_valid,
        input  busy
    );
endinterface

// File: rtl/three_phase_lut_scheduler.sv
// Shares one half-wave sine ROM among three phase channels; one atomic A/B/C update per sample tick.
module three_phase_lut_scheduler #(
    parameter int unsigned LUT_DEPTH = 10000,
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned ROM_LAT   = 1,
    parameter int unsigned TICK_DIV  = 12,
    parameter int unsigned PHASE_OFF = 6667
) (
    input  logic                        clk,
    input  logic                        rst,
    three_phase_lut_scheduler_if.master bus
);
    localparam int unsigned IDX_W  = ADDR_W + 1;
    localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned TAGS_W = TAG_W * ROM_LAT;

    localparam logic [IDX_W-1:0] IDX_HALF  = IDX_W'(LUT_DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(2 * LUT_DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_B_RST = IDX_W'(2 * LUT_DEPTH - PHASE_OFF);
    localparam logic [IDX_W-1:0] IDX_C_RST = IDX_W'(2 * LUT_DEPTH - 2 * PHASE_OFF);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [1:0]       CH_A      = 2'd0;
    localparam logic [1:0]       CH_B      = 2'd1;
    localparam logic [1:0]       CH_C      = 2'd2;

    // Reject configurations where a tick could land mid-sequence or indices cannot be addressed.
    generate
        if (ROM_LAT < 1 || TICK_DIV < 5 + ROM_LAT || (64'(1) << ADDR_W) < 64'(LUT_DEPTH) ||
            PHASE_OFF == 0 || PHASE_OFF > LUT_DEPTH) begin : g_bad_cfg
            $fatal(1, "three_phase_lut_scheduler: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, RD_C, WAIT_C, COMMIT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_a_q, idx_a_d, idx_b_q, idx_b_d, idx_c_q, idx_c_d;
    logic [DATA_W-1:0] shadow_a_q, shadow_a_d, shadow_b_q, shadow_b_d, shadow_c_q, shadow_c_d;
    logic [DATA_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d, out_c_q, out_c_d;
    logic              out_valid_q, out_valid_d;
    logic              rom_rd_q, rom_rd_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              busy_q, busy_d;
    // Read-tag pipeline: {valid, negate, channel[1:0]} per stage, oldest stage at the top.
    logic [TAGS_W-1:0] tag_q, tag_d;

    logic              tick_c;
    logic              rd_neg_c;
    logic [1:0]        rd_ch_c;
    logic [TAG_W-1:0]  tag_head_c;
    logic [DATA_W-1:0] cap_c;
    logic              c_done_c;

    // Fold a full-wave index onto the half-wave ROM.
    function automatic logic [ADDR_W-1:0] rom_addr_of(input logic [IDX_W-1:0] idx);
        return (idx >= IDX_HALF) ? ADDR_W'(idx - IDX_HALF) : ADDR_W'(idx);
    endfunction

    // Advance an index by one sample, wrapping at the full period.
    function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx);
        return (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    endfunction

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_a_d     = idx_a_q;
        idx_b_d     = idx_b_q;
        idx_c_d     = idx_c_q;
        shadow_a_d  = shadow_a_q;
        shadow_b_d  = shadow_b_q;
        shadow_c_d  = shadow_c_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_c_d     = out_c_q;
        out_valid_d = 1'b0;
        rom_rd_d    = 1'b0;
        rom_addr_d  = '0;
        rd_ch_c     = CH_A;
        rd_neg_c    = 1'b0;

        tick_c = bus.en && (cnt_q == CNT_LAST);
        if (bus.en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end

        // Tag the read issued this cycle so its data is steered and signed on return.
        case (state_q)
            RD_A:    begin rd_ch_c = CH_A; rd_neg_c = (idx_a_q >= IDX_HALF); end
            RD_B:    begin rd_ch_c = CH_B; rd_neg_c = (idx_b_q >= IDX_HALF); end
            RD_C:    begin rd_ch_c = CH_C; rd_neg_c = (idx_c_q >= IDX_HALF); end
            default: ;
        endcase
        tag_d = TAGS_W'(tag_q << TAG_W) | TAGS_W'({rom_rd_q, rd_neg_c, rd_ch_c});

        tag_head_c = tag_q[TAGS_W-1 -: TAG_W];
        cap_c      = tag_head_c[2] ? (DATA_W'(0) - bus.rom_data) : bus.rom_data;
        c_done_c   = tag_head_c[3] && (tag_head_c[1:0] == CH_C);
        if (tag_head_c[3]) begin
            case (tag_head_c[1:0])
                CH_A:    shadow_a_d = cap_c;
                CH_B:    shadow_b_d = cap_c;
                default: shadow_c_d = cap_c;
            endcase
        end

        case (state_q)
            IDLE:    if (tick_c) state_d = RD_A;
            RD_A:    state_d = RD_B;
            RD_B:    state_d = RD_C;
            RD_C:    state_d = WAIT_C;
            WAIT_C:  if (c_done_c) state_d = COMMIT;
            COMMIT: begin
                state_d     = IDLE;
                out_a_d     = shadow_a_q;
                out_b_d     = shadow_b_q;
                out_c_d     = shadow_c_q;
                out_valid_d = 1'b1;
                idx_a_d     = idx_next(idx_a_q);
                idx_b_d     = idx_next(idx_b_q);
                idx_c_d     = idx_next(idx_c_q);
            end
            default: state_d = IDLE;
        endcase

        // ROM strobe and address are registered, so they follow the state being entered.
        case (state_d)
            RD_A:    begin rom_rd_d = 1'b1; rom_addr_d = rom_addr_of(idx_a_q); end
            RD_B:    begin rom_rd_d = 1'b1; rom_addr_d = rom_addr_of(idx_b_q); end
            RD_C:    begin rom_rd_d = 1'b1; rom_addr_d = rom_addr_of(idx_c_q); end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset also discards any read still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_a_q     <= '0;
            idx_b_q     <= IDX_B_RST;
            idx_c_q     <= IDX_C_RST;
            shadow_a_q  <= '0;
            shadow_b_q  <= '0;
            shadow_c_q  <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_c_q     <= '0;
            out_valid_q <= 1'b0;
            rom_rd_q    <= 1'b0;
            rom_addr_q  <= '0;
            busy_q      <= 1'b0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_a_q     <= idx_a_d;
            idx_b_q     <= idx_b_d;
            idx_c_q     <= idx_c_d;
            shadow_a_q  <= shadow_a_d;
            shadow_b_q  <= shadow_b_d;
            shadow_c_q  <= shadow_c_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_c_q     <= out_c_d;
            out_valid_q <= out_valid_d;
            rom_rd_q    <= rom_rd_d;
            rom_addr_q  <= rom_addr_d;
            busy_q      <= busy_d;
            tag_q       <= tag_d;
        end
    end

    assign bus.rom_rd    = rom_rd_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_c     = out_c_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_three_phase_lut_scheduler.sv
// Bench for three_phase_lut_scheduler: default instance plus a small fast-wrapping instance, both against a model.
module tb_three_phase_lut_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_drv = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input int g, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got 0x%0h want 0x%0h at %0t", name, g, act, exp, $time);
            if (errors >= 200) begin
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam bit          IS0 = (g == 0);
        localparam int unsigned L   = IS0 ? 10000 : 10;
        localparam int unsigned P   = IS0 ? 6667 : 7;
        localparam int unsigned LAT = IS0 ? 1 : 2;
        localparam int unsigned TD  = IS0 ? 12 : 7;
        localparam int unsigned RPW = 12 * LAT;

        three_phase_lut_scheduler_if #(.DATA_W(12), .ADDR_W(14)) bus ();

        three_phase_lut_scheduler #(
            .LUT_DEPTH(L), .DATA_W(12), .ADDR_W(14), .ROM_LAT(LAT), .TICK_DIV(TD), .PHASE_OFF(P)
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus.master)
        );

        assign bus.en = en_drv;

        function automatic logic [11:0] rom_f(input int a);
            return IS0 ? 12'(a) : 12'(a * 37 + 5);
        endfunction

        function automatic int addr_of(input int idx);
            return (idx < int'(L)) ? idx : idx - int'(L);
        endfunction

        function automatic logic [11:0] smp(input int idx);
            logic [11:0] d;
            d = rom_f(addr_of(idx));
            return (idx >= int'(L)) ? (12'd0 - d) : d;
        endfunction

        // ROM: word valid exactly LAT cycles after the read, noise at all other times.
        logic [RPW-1:0] rp;
        always @(posedge clk) begin
            rp <= RPW'({rp, (bus.rom_rd ? rom_f(int'(bus.rom_addr)) : 12'($urandom))});
        end
        assign bus.rom_data = rp[RPW-1 -: 12];

        // Reference: p = cycles since the tick cycle T (0 = no sequence in flight).
        int          m_cnt, m_p, m_p_nx, ia, ib, ic;
        logic [11:0] ea, eb, ec;
        bit          m_tick;
        assign m_tick = en_drv && (m_cnt == int'(TD) - 1);
        assign m_p_nx = m_tick ? 1 : ((m_p > 0 && m_p < 5 + int'(LAT)) ? m_p + 1 : 0);

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                m_cnt <= 0;
                m_p   <= 0;
                ia    <= 0;
                ib    <= 2 * int'(L) - int'(P);
                ic    <= 2 * int'(L) - 2 * int'(P);
                ea    <= '0;
                eb    <= '0;
                ec    <= '0;
            end else begin
                if (en_drv) m_cnt <= (m_cnt + 1) % int'(TD);
                m_p <= m_p_nx;
                if (m_p_nx == 5 + int'(LAT)) begin
                    ea <= smp(ia);
                    eb <= smp(ib);
                    ec <= smp(ic);
                    ia <= (ia + 1) % (2 * int'(L));
                    ib <= (ib + 1) % (2 * int'(L));
                    ic <= (ic + 1) % (2 * int'(L));
                end
            end
        end

        // Per-cycle comparison against the reference.
        always @(negedge clk) begin
            if (!rst) begin
                chk(g, "rom_rd", 32'(bus.rom_rd), 32'(m_p >= 1 && m_p <= 3));
                if (m_p >= 1 && m_p <= 3)
                    chk(g, "rom_addr", 32'(bus.rom_addr),
                        32'(addr_of((m_p == 1) ? ia : (m_p == 2) ? ib : ic)));
                chk(g, "busy", 32'(bus.busy), 32'(m_p >= 1 && m_p <= 4 + int'(LAT)));
                chk(g, "out_valid", 32'(bus.out_valid), 32'(m_p == 5 + int'(LAT)));
                chk(g, "out_a", 32'(bus.out_a), 32'(ea));
                chk(g, "out_b", 32'(bus.out_b), 32'(eb));
                chk(g, "out_c", 32'(bus.out_c), 32'(ec));
            end
        end
    end

    // Reset, release, and pin the first default-instance sequence to hand-computed values.
    task automatic first_tick_literals();
        rst    = 1'b1;
        en_drv = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        for (int cyc = 1; cyc <= 17; cyc++) begin
            @(posedge clk);
            #1;
            case (cyc)
                11: chk(0, "lit_rd_c11", 32'(g_inst[0].bus.rom_rd), 32'd0);
                12: begin
                    chk(0, "lit_rd_c12", 32'(g_inst[0].bus.rom_rd), 32'd1);
                    chk(0, "lit_addr_a", 32'(g_inst[0].bus.rom_addr), 32'd0);
                end
                13: chk(0, "lit_addr_b", 32'(g_inst[0].bus.rom_addr), 32'd3333);
                14: chk(0, "lit_addr_c", 32'(g_inst[0].bus.rom_addr), 32'd6666);
                15: chk(0, "lit_rd_c15", 32'(g_inst[0].bus.rom_rd), 32'd0);
                16: chk(0, "lit_valid_c16", 32'(g_inst[0].bus.out_valid), 32'd0);
                17: begin
                    chk(0, "lit_valid_c17", 32'(g_inst[0].bus.out_valid), 32'd1);
                    chk(0, "lit_out_a", 32'(g_inst[0].bus.out_a), 32'd0);
                    // -3333 in 12-bit two's complement
                    chk(0, "lit_out_b", 32'(g_inst[0].bus.out_b), 32'd763);
                    // 6666 truncated to 12 bits
                    chk(0, "lit_out_c", 32'(g_inst[0].bus.out_c), 32'd2570);
                end
                default: ;
            endcase
        end
    endtask

    // Drop en during the second read: one commit, no further reads, divider resumes from held count.
    task automatic en_drop_check();
        int reads = 0;
        int vals  = 0;
        int n     = 0;
        bit found = 1'b0;
        for (int k = 0; k < 40 && g_inst[0].bus.busy; k++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (g_inst[0].bus.rom_rd) begin
                found = 1'b1;
                break;
            end
        end
        chk(0, "en_drop_found_rd", 32'(found), 32'd1);
        @(posedge clk);
        #1 en_drv = 1'b0;
        for (int i = 0; i < 30; i++) begin
            reads += int'(g_inst[0].bus.rom_rd);
            vals  += int'(g_inst[0].bus.out_valid);
            @(posedge clk);
            #1;
        end
        chk(0, "en_drop_reads", 32'(reads), 32'd2);
        chk(0, "en_drop_commits", 32'(vals), 32'd1);
        en_drv = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (g_inst[0].bus.rom_rd) break;
        end
        chk(0, "en_resume_delay", 32'(n), 32'd11);
    endtask

    initial begin
        int  n0;
        int  n1;
        bit  seen;

        first_tick_literals();
        en_drop_check();

        // Randomised enable activity.
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 15) == 0) en_drv = ~en_drv;
        end

        // Asynchronous reset in the middle of a sequence.
        en_drv = 1'b1;
        seen   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (g_inst[0].bus.busy) begin
                seen = 1'b1;
                break;
            end
        end
        chk(0, "rst_busy_seen", 32'(seen), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk(0, "rst_out_a", 32'(g_inst[0].bus.out_a), 32'd0);
        chk(0, "rst_out_b", 32'(g_inst[0].bus.out_b), 32'd0);
        chk(0, "rst_out_c", 32'(g_inst[0].bus.out_c), 32'd0);
        chk(0, "rst_valid", 32'(g_inst[0].bus.out_valid), 32'd0);
        chk(0, "rst_rom_rd", 32'(g_inst[0].bus.rom_rd), 32'd0);
        chk(0, "rst_rom_addr", 32'(g_inst[0].bus.rom_addr), 32'd0);
        chk(0, "rst_busy", 32'(g_inst[0].bus.busy), 32'd0);
        chk(1, "rst_out_a", 32'(g_inst[1].bus.out_a), 32'd0);
        chk(1, "rst_out_b", 32'(g_inst[1].bus.out_b), 32'd0);
        chk(1, "rst_out_c", 32'(g_inst[1].bus.out_c), 32'd0);
        chk(1, "rst_busy", 32'(g_inst[1].bus.busy), 32'd0);
        first_tick_literals();

        // Long steady run: pulse count fixed by the tick period.
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 28000; i++) begin
            @(posedge clk);
            #1;
            n0 += int'(g_inst[0].bus.out_valid);
            n1 += int'(g_inst[1].bus.out_valid);
        end
        chk(1, "long_pulses", 32'(n1), 32'd4000);
        chk(0, "long_pulses_range", 32'(n0 == 2333 || n0 == 2334), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
